// File: rtl/router_fsm.sv
// Control FSM for a 1-input/3-output packet router: decodes the header address,
// sequences header/payload/parity loading and reports busy back to the source.
module router_fsm (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       ld_state,
    output logic       laf_state,
    output logic       lfd_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CHAN_N = 4;

    typedef enum logic [2:0] {
        ST_DA  = 3'd0,
        ST_LFD = 3'd1,
        ST_LD  = 3'd2,
        ST_WTE = 3'd3,
        ST_FFS = 3'd4,
        ST_LAF = 3'd5,
        ST_LP  = 3'd6,
        ST_CPE = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    // Channel 3 is not a real channel; its slot reads as never-empty / never-reset.
    logic [CHAN_N-1:0]   empty_vec;
    logic [CHAN_N-1:0]   soft_vec;
    logic                soft_hit;
    logic                hdr_ok;

    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign soft_hit  = soft_vec[addr_q];
    assign hdr_ok    = pkt_valid && (data_in != 2'd3);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_DA;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == ST_DA) begin
            addr_d = data_in;
        end
        if (soft_hit) begin
            state_d = ST_DA;
        end else begin
            unique case (state_q)
                ST_DA: begin
                    if (hdr_ok) begin
                        state_d = empty_vec[data_in] ? ST_LFD : ST_WTE;
                    end
                end
                ST_LFD: state_d = ST_LD;
                ST_LD: begin
                    if (fifo_full) begin
                        state_d = ST_FFS;
                    end else if (!pkt_valid) begin
                        state_d = ST_LP;
                    end
                end
                ST_FFS: begin
                    if (!fifo_full) begin
                        state_d = ST_LAF;
                    end
                end
                ST_LAF: begin
                    if (parity_done) begin
                        state_d = ST_DA;
                    end else if (low_pkt_valid) begin
                        state_d = ST_LP;
                    end else begin
                        state_d = ST_LD;
                    end
                end
                ST_LP:  state_d = ST_CPE;
                ST_CPE: state_d = fifo_full ? ST_FFS : ST_DA;
                ST_WTE: begin
                    if (empty_vec[addr_q]) begin
                        state_d = ST_LFD;
                    end
                end
                default: state_d = ST_DA;
            endcase
        end
    end

    always_comb begin
        write_enb_reg = 1'b0;
        detect_add    = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        lfd_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        unique case (state_q)
            ST_DA:  detect_add = 1'b1;
            ST_LFD: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            ST_LD: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_FFS: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            ST_LAF: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            ST_LP: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            ST_CPE: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            ST_WTE: busy = 1'b1;
            default: detect_add = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed and randomized checks of router_fsm against a behavioural model
// built from the router's state/transition rules.
module tb_router_fsm;

    logic       clk;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       write_enb_reg, detect_add, ld_state, laf_state;
    logic       lfd_state, full_state, rst_int_reg, busy;

    router_fsm dut (
        .clk           (clk),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .write_enb_reg (write_enb_reg),
        .detect_add    (detect_add),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .lfd_state     (lfd_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {M_DA, M_LFD, M_LD, M_WTE, M_FFS, M_LAF, M_LP, M_CPE} ms_t;

    ms_t        m_state;
    logic [1:0] m_addr;
    int         n_assert;
    int         n_fail;

    // {detect_add, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy}
    logic [7:0] obs;
    assign obs = {detect_add, lfd_state, ld_state, full_state, laf_state,
                  rst_int_reg, write_enb_reg, busy};

    function automatic logic [7:0] exp_out(input ms_t s);
        case (s)
            M_DA:    return 8'b1000_0000;
            M_LFD:   return 8'b0100_0001;
            M_LD:    return 8'b0010_0010;
            M_FFS:   return 8'b0001_0001;
            M_LAF:   return 8'b0000_1011;
            M_LP:    return 8'b0000_0011;
            M_CPE:   return 8'b0000_0101;
            default: return 8'b0000_0001;
        endcase
    endfunction

    function automatic bit chan_empty(input int k);
        if (k == 0) return fifo_empty_0 == 1'b1;
        if (k == 1) return fifo_empty_1 == 1'b1;
        if (k == 2) return fifo_empty_2 == 1'b1;
        return 1'b0;
    endfunction

    function automatic bit chan_soft(input int k);
        if (k == 0) return soft_reset_0 == 1'b1;
        if (k == 1) return soft_reset_1 == 1'b1;
        if (k == 2) return soft_reset_2 == 1'b1;
        return 1'b0;
    endfunction

    function automatic ms_t model_next();
        int a;
        int d;
        a = int'(m_addr);
        d = int'(data_in);
        if (chan_soft(a)) return M_DA;
        case (m_state)
            M_DA:  if (pkt_valid && d < 3) return chan_empty(d) ? M_LFD : M_WTE;
                   else return M_DA;
            M_LFD: return M_LD;
            M_LD:  if (fifo_full) return M_FFS;
                   else if (!pkt_valid) return M_LP;
                   else return M_LD;
            M_FFS: return fifo_full ? M_FFS : M_LAF;
            M_LAF: if (parity_done) return M_DA;
                   else if (low_pkt_valid) return M_LP;
                   else return M_LD;
            M_LP:  return M_CPE;
            M_CPE: return fifo_full ? M_FFS : M_DA;
            default: return chan_empty(a) ? M_LFD : M_WTE;
        endcase
    endfunction

    // One clock: advance the model from the current inputs and compare.
    task automatic step(input string tag);
        ms_t        nxt;
        logic [1:0] na;
        if (!resetn) begin
            nxt = M_DA;
            na  = 2'd0;
        end else begin
            nxt = model_next();
            na  = (m_state == M_DA) ? data_in : m_addr;
        end
        @(posedge clk);
        m_state = nxt;
        m_addr  = na;
        #1;
        n_assert++;
        assert (obs === exp_out(m_state)) else begin
            n_fail++;
            $error("FAIL %s model: observed=%b expected=%b", tag, obs, exp_out(m_state));
        end
    endtask

    // Directed expectation taken straight from the test plan sequence.
    task automatic expect_st(input string tag, input ms_t s);
        n_assert++;
        assert (obs === exp_out(s)) else begin
            n_fail++;
            $error("FAIL %s plan: observed=%b expected=%b", tag, obs, exp_out(s));
        end
    endtask

    task automatic idle_inputs();
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        fifo_full     = 1'b0;
        fifo_empty_0  = 1'b0;
        fifo_empty_1  = 1'b0;
        fifo_empty_2  = 1'b0;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
    endtask

    task automatic header(input logic [1:0] a);
        pkt_valid = 1'b1;
        data_in   = a;
        fifo_empty_0 = (a == 2'd0);
        fifo_empty_1 = (a == 2'd1);
        fifo_empty_2 = (a == 2'd2);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_state  = M_DA;
        m_addr   = 2'd0;
        idle_inputs();
        resetn = 1'b0;
        step("reset");      expect_st("reset", M_DA);
        resetn = 1'b1;

        // Uncongested one-byte payload
        header(2'd1);
        step("t1_lfd");     expect_st("t1_lfd", M_LFD);
        step("t1_ld");      expect_st("t1_ld", M_LD);
        pkt_valid = 1'b0;
        step("t1_lp");      expect_st("t1_lp", M_LP);
        step("t1_cpe");     expect_st("t1_cpe", M_CPE);
        step("t1_da");      expect_st("t1_da", M_DA);

        // FIFO full in LD, parity pending after full
        header(2'd1);
        step("t2_lfd");     expect_st("t2_lfd", M_LFD);
        step("t2_ld");      expect_st("t2_ld", M_LD);
        fifo_full = 1'b1;
        step("t2_ffs");     expect_st("t2_ffs", M_FFS);
        fifo_full = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b1;
        step("t2_laf");     expect_st("t2_laf", M_LAF);
        step("t2_lp");      expect_st("t2_lp", M_LP);
        low_pkt_valid = 1'b0;
        step("t2_cpe");     expect_st("t2_cpe", M_CPE);
        step("t2_da");      expect_st("t2_da", M_DA);

        // LAF back to LD while payload continues
        header(2'd1);
        step("t3_lfd");
        step("t3_ld");
        fifo_full = 1'b1;
        step("t3_ffs");     expect_st("t3_ffs", M_FFS);
        fifo_full = 1'b0;
        step("t3_laf");     expect_st("t3_laf", M_LAF);
        step("t3_ld2");     expect_st("t3_ld2", M_LD);
        pkt_valid = 1'b0;
        step("t3_lp");      expect_st("t3_lp", M_LP);
        step("t3_cpe");
        step("t3_da");      expect_st("t3_da", M_DA);

        // parity_done in LAF, then FIFO full during CPE
        header(2'd0);
        step("t4_lfd");
        step("t4_ld");
        fifo_full = 1'b1;
        step("t4_ffs");
        fifo_full = 1'b0; parity_done = 1'b1;
        step("t4_laf");     expect_st("t4_laf", M_LAF);
        pkt_valid = 1'b0;
        step("t4_da");      expect_st("t4_da", M_DA);
        parity_done = 1'b0;
        header(2'd0);
        step("t4_lfd2");
        step("t4_ld2");
        pkt_valid = 1'b0;
        step("t4_lp");
        fifo_full = 1'b1;
        step("t4_cpe");     expect_st("t4_cpe", M_CPE);
        step("t4_ffs2");    expect_st("t4_ffs2", M_FFS);
        fifo_full = 1'b0; parity_done = 1'b1;
        step("t4_laf2");
        step("t4_da2");     expect_st("t4_da2", M_DA);
        parity_done = 1'b0;

        // Wait-till-empty and soft reset handling
        idle_inputs();
        pkt_valid = 1'b1; data_in = 2'd2;
        step("t5_wte");     expect_st("t5_wte", M_WTE);
        step("t5_wte2");    expect_st("t5_wte2", M_WTE);
        fifo_empty_2 = 1'b1;
        step("t5_lfd");     expect_st("t5_lfd", M_LFD);
        pkt_valid = 1'b0;
        step("t5_ld");
        step("t5_lp");
        step("t5_cpe");
        step("t5_da");      expect_st("t5_da", M_DA);
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        step("t5_wte3");    expect_st("t5_wte3", M_WTE);
        pkt_valid = 1'b0; soft_reset_0 = 1'b1;
        step("t5_sr0");     expect_st("t5_sr0", M_WTE);
        soft_reset_0 = 1'b0; soft_reset_2 = 1'b1;
        step("t5_sr2");     expect_st("t5_sr2", M_DA);
        soft_reset_2 = 1'b0;

        // Invalid address and mid-packet reset
        idle_inputs();
        pkt_valid = 1'b1; data_in = 2'd3; fifo_empty_0 = 1'b1;
        fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        step("t6_inv");     expect_st("t6_inv", M_DA);
        step("t6_inv2");    expect_st("t6_inv2", M_DA);
        data_in = 2'd0;
        step("t6_lfd");
        step("t6_ld");      expect_st("t6_ld", M_LD);
        resetn = 1'b0;
        step("t6_rst");     expect_st("t6_rst", M_DA);
        resetn = 1'b1;

        // Randomized phase against the model
        for (int i = 0; i < 600; i++) begin
            resetn        = ($urandom_range(0, 59) != 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty_0  = 1'($urandom_range(0, 1));
            fifo_empty_1  = 1'($urandom_range(0, 1));
            fifo_empty_2  = 1'($urandom_range(0, 1));
            soft_reset_0  = ($urandom_range(0, 19) == 0);
            soft_reset_1  = ($urandom_range(0, 19) == 0);
            soft_reset_2  = ($urandom_range(0, 19) == 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Moore control FSM for a 1-input/3-output packet router.
- Decodes the 2-bit destination address in a packet header.
- Sequences header, payload and parity loading into the register/FIFO datapath.
- Handles FIFO-full back-pressure and per-channel soft resets, and drives load strobes plus a busy flag back to the source.

Parameters:
- none. State encoding is internal; any 3-bit encoding is acceptable.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- resetn  in  1  synchronous, active-low reset
- pkt_valid  in  1  source has a valid packet byte; deasserts after the last payload byte
- data_in  in  2  destination address (header bits [1:0]); 0,1,2 valid, 3 invalid
- fifo_full  in  1  FIFO currently being written is full
- fifo_empty_0  in  1  FIFO 0 empty
- fifo_empty_1  in  1  FIFO 1 empty
- fifo_empty_2  in  1  FIFO 2 empty
- soft_reset_0  in  1  channel 0 read-timeout soft reset
- soft_reset_1  in  1  channel 1 read-timeout soft reset
- soft_reset_2  in  1  channel 2 read-timeout soft reset
- parity_done  in  1  register block has captured the parity byte
- low_pkt_valid  in  1  pkt_valid fell while the FIFO was full (parity byte pending)
- write_enb_reg  out  1  write enable to the FIFO from the register block
- detect_add  out  1  in DECODE_ADDRESS
- ld_state  out  1  in LOAD_DATA
- laf_state  out  1  in LOAD_AFTER_FULL
- lfd_state  out  1  in LOAD_FIRST_DATA
- full_state  out  1  in FIFO_FULL_STATE
- rst_int_reg  out  1  in CHECK_PARITY_ERROR; clears internal parity registers
- busy  out  1  router cannot accept a new byte this cycle

Behaviour:
- One clock (clk). Reset is synchronous and active-low (resetn): on a rising clk edge with resetn=0, state := DECODE_ADDRESS and addr := 0.
- After reset: detect_add=1; every other output is 0.
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), WAIT_TILL_EMPTY (WTE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE).
- Address register addr[1:0]: loaded from data_in on every clock spent in DA. Held in all other states.
- Soft reset has priority over all transitions except resetn. If soft_reset_k=1 and addr==k, next state is DA. Soft resets on other channels are ignored.
- DA:
  - pkt_valid=1, data_in=k (k in 0..2) and fifo_empty_k=1 -> LFD.
  - pkt_valid=1, data_in=k and fifo_empty_k=0 -> WTE.
  - Otherwise (pkt_valid=0, or data_in=3) stay in DA.
- LFD -> LD unconditionally. LFD lasts exactly 1 cycle.
- LD:
  - fifo_full=1 -> FFS (this has priority).
  - Else pkt_valid=0 -> LP.
  - Else stay in LD.
- FFS: fifo_full=0 -> LAF; else stay in FFS.
- LAF:
  - parity_done=1 -> DA.
  - Else low_pkt_valid=1 -> LP.
  - Else -> LD.
- LP -> CPE unconditionally. LP lasts 1 cycle.
- CPE: fifo_full=1 -> FFS; else -> DA.
- WTE: fifo_empty_addr=1 (the empty flag of the latched channel) -> LFD; else stay in WTE.
- Outputs are Moore, decoded combinationally from the current state only:
  - detect_add=DA, lfd_state=LFD, ld_state=LD, full_state=FFS, laf_state=LAF, rst_int_reg=CPE.
  - write_enb_reg = LD | LAF | LP.
  - busy = LFD | FFS | LAF | LP | CPE | WTE. busy=0 only in DA and LD.
- Exactly one state-strobe output is high in each state, except in LP and WTE, where no strobe is high.
- Reset asserted mid-packet from any state: DA on the next rising edge. No residual outputs.
- Latency for an uncongested 1-byte payload: DA->LFD->LD->LP->CPE->DA, i.e. 4 cycles after the header is accepted until detect_add returns.

Test Plan:
- Reset, then pkt_valid=1, data_in=1, fifo_empty_1=1; drop pkt_valid after 2 cycles -> sequence DA, LFD (busy=1), LD (write_enb_reg=1, busy=0), LP (write_enb_reg=1, busy=1), CPE (rst_int_reg=1), DA (detect_add=1).
- Same header; fifo_full=1 while in LD for 1 cycle, then low_pkt_valid=1, parity_done=0 -> LD, FFS (full_state=1, busy=1), LAF (laf_state=1, write_enb_reg=1), LP, CPE, DA.
- Same as the previous case but low_pkt_valid=0 and pkt_valid held -> LAF returns to LD; dropping pkt_valid -> LP, CPE, DA.
- Full packet with parity_done=1 arriving in LAF -> LAF goes directly to DA; fifo_full=1 in CPE -> FFS.
- data_in=2, fifo_empty_2=0 -> WTE (busy=1, no strobes); raise fifo_empty_2 -> LFD. Repeat, but assert soft_reset_2 in WTE -> DA; soft_reset_0 in WTE -> no effect.
- data_in=3 with pkt_valid=1 -> stays in DA (detect_add=1). resetn=0 while in LD -> DA on the next edge.
